// File: rtl/popcount_seq_ctrl.sv
// popcount_seq_ctrl: counts the 1-bits of an N-bit word, C bits per clock.
// A word is accepted in IDLE, consumed over B = N/C beats in BUSY, and the
// result is held in DONE until the downstream handshake or an abort.
module popcount_seq_ctrl #(
  parameter  int N  = 32,
  parameter  int C  = 8,
  localparam int CW = $clog2(N + 1),
  localparam int B  = N / C
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  d_in,
  input  logic          abort,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] count,
  output logic          busy,
  output logic [7:0]    words_done
);

  // Beat counter is at least one bit wide so the B=1 case still elaborates.
  localparam int            BW        = (B > 1) ? $clog2(B) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(B - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  shift_q, shift_d;
  logic [CW-1:0] acc_q, acc_d;
  logic [CW-1:0] count_q, count_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [7:0]    words_q, words_d;
  logic [CW-1:0] chunk_cnt;
  logic [CW-1:0] sum;

  // Ones in the low C bits of the shift register: this beat's contribution.
  always_comb begin
    chunk_cnt = '0;
    for (int i = 0; i < C; i++) begin
      chunk_cnt = chunk_cnt + CW'(shift_q[i]);
    end
  end

  // Running total including the current beat; never exceeds N, so CW bits suffice.
  assign sum = acc_q + chunk_cnt;

  // Next-state and datapath update for the IDLE/BUSY/DONE controller.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d = state_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    count_d = count_q;
    beat_d  = beat_q;
    words_d = words_q;

    case (state_q)
      IDLE: begin
        // abort has no meaning here; a valid word is taken regardless.
        if (in_valid) begin
          shift_d = d_in;
          acc_d   = '0;
          beat_d  = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (abort) begin
          acc_d   = '0;
          state_d = IDLE;
        end else begin
          acc_d   = sum;
          shift_d = shift_q >> C;
          beat_d  = beat_q + BW'(1);
          if (beat_q == LAST_BEAT) begin
            count_d = sum;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // Abort takes priority: the result is dropped and not counted.
        if (abort) begin
          state_d = IDLE;
        end else if (out_ready) begin
          words_d = words_q + 8'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      acc_q   <= '0;
      count_q <= '0;
      beat_q  <= '0;
      words_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      beat_q  <= beat_d;
      words_q <= words_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign count      = count_q;
  assign words_done = words_q;

endmodule

// File: tb/tb_popcount_seq_ctrl.sv
// Self-checking bench for popcount_seq_ctrl (N=32, C=8): vector table plus
// hand-written sequences for back-pressure, ignored input, abort and reset.
module tb_popcount_seq_ctrl;

  localparam int N  = 32;
  localparam int C  = 8;
  localparam int CW = $clog2(N + 1);
  localparam int B  = N / C;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  d_in;
  logic          abort;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          busy;
  logic [7:0]    words_done;

  int checks = 0;
  int errors = 0;

  logic [CW-1:0] sb_q[$];
  logic [CW-1:0] exp_count_reg;
  logic [7:0]    exp_words;

  typedef struct {
    logic [N-1:0]  d;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  popcount_seq_ctrl #(.N(N), .C(C)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .d_in       (d_in),
    .abort      (abort),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .count      (count),
    .busy       (busy),
    .words_done (words_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: compare every completed handshake against the oldest expected result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready && !abort) begin
      if (sb_q.size() == 0) check("unexpected_result", 32'(count), 32'hFFFF_FFFF);
      else check("sb_count", 32'(count), 32'(sb_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word in IDLE; returns 1 ns after the acceptance edge.
  task automatic send(input logic [N-1:0] d, input logic [CW-1:0] cnt,
                      input bit push, input bit ab);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("accept_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    d_in     = d;
    abort    = ab;
    if (push) sb_q.push_back(cnt);
    tick();
    in_valid = 1'b0;
    abort    = 1'b0;
    d_in     = $urandom();
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  // Wait (bounded) for out_valid; k counts edges since acceptance.
  task automatic wait_result(input int start, input int exp_lat, input logic [CW-1:0] cnt);
    int k = start;
    while (!out_valid && k < 20) begin
      tick();
      k++;
    end
    check("latency", 32'(k), 32'(exp_lat));
    check("count_at_valid", 32'(count), 32'(cnt));
    exp_count_reg = cnt;
  endtask

  // Completion edge with out_ready high: back to IDLE on the very next cycle.
  task automatic finish_word();
    tick();
    exp_words++;
    check("in_ready_after_done", 32'(in_ready), 32'd1);
    check("out_valid_after_done", 32'(out_valid), 32'd0);
    check("words_done", 32'(words_done), 32'(exp_words));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'hFFFF_FFFF, 6'd32};
    vecs[1] = '{32'hF0F0_0001, 6'd9};
    vecs[2] = '{32'h8000_0001, 6'd2};
    vecs[3] = '{32'h0000_000F, 6'd4};
    vecs[4] = '{32'h00FF_00FF, 6'd16};
    vecs[5] = '{32'hAAAA_AAAA, 6'd16};
    vecs[6] = '{32'h0000_0001, 6'd1};
    vecs[7] = '{32'h8000_0000, 6'd1};

    in_valid  = 1'b0;
    d_in      = '0;
    abort     = 1'b0;
    out_ready = 1'b0;
    exp_words = 8'd0;
    exp_count_reg = '0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_words_done", 32'(words_done), 32'd0);
    rst = 1'b0;
    tick();

    // Zero word; out_ready held high, including while out_valid is low.
    out_ready = 1'b1;
    send(32'h0000_0000, 6'd0, 1'b1, 1'b0);
    wait_result(0, B, 6'd0);
    finish_word();

    // Vector table, back-to-back words.
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].d, vecs[i].cnt, 1'b1, 1'b0);
      wait_result(0, B, vecs[i].cnt);
      finish_word();
    end

    // Back-pressure: result held for 6 cycles, in_valid ignored meanwhile.
    out_ready = 1'b0;
    send(32'h8000_0001, 6'd2, 1'b1, 1'b0);
    wait_result(0, B, 6'd2);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      d_in     = $urandom();
      tick();
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_count", 32'(count), 32'd2);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    finish_word();

    // in_valid with a different word during BUSY is ignored.
    send(32'h0000_000F, 6'd4, 1'b1, 1'b0);
    in_valid = 1'b1;
    d_in     = 32'h1234_5678;
    tick();
    tick();
    in_valid = 1'b0;
    wait_result(2, B, 6'd4);
    finish_word();
    for (int i = 0; i < 6; i++) begin
      tick();
      check("no_extra_result", 32'(out_valid), 32'd0);
    end

    // Abort on beat 2 of a BUSY word.
    send(32'hFFFF_FFFF, 6'd32, 1'b0, 1'b0);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy_in_ready", 32'(in_ready), 32'd1);
    check("abort_busy_busy", 32'(busy), 32'd0);
    check("abort_busy_count", 32'(count), 32'(exp_count_reg));
    check("abort_busy_words", 32'(words_done), 32'(exp_words));
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_busy_no_valid", 32'(out_valid), 32'd0);
    end

    // Abort in DONE drops the result without counting it.
    out_ready = 1'b0;
    send(32'h0000_0003, 6'd2, 1'b0, 1'b0);
    wait_result(0, B, 6'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_done_in_ready", 32'(in_ready), 32'd1);
    check("abort_done_out_valid", 32'(out_valid), 32'd0);
    check("abort_done_words", 32'(words_done), 32'(exp_words));
    check("abort_done_count", 32'(count), 32'd2);

    // Abort in IDLE is ignored and the word is accepted.
    out_ready = 1'b1;
    send(32'h0000_0007, 6'd3, 1'b1, 1'b1);
    wait_result(0, B, 6'd3);
    finish_word();

    // Asynchronous reset between edges in the middle of BUSY.
    send(32'hFFFF_FFFF, 6'd32, 1'b0, 1'b0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_words_done", 32'(words_done), 32'd0);
    exp_words = 8'd0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    send(32'h00FF_00FF, 6'd16, 1'b1, 1'b0);
    wait_result(0, B, 6'd16);
    finish_word();

    tick();
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
